// File: rtl/lock_pkg.sv
// lock_pkg: definitions shared by the lock's keypad entry path.
//   kp_state_t : keypad scanner FSM states.
//   KEY_*      : 4-bit key codes for the non-digit keys (digits use 0-9).
//   kp_code()  : maps a (row, column) keypad position to its key code.
package lock_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2,
    RELEASE  = 2'd3
  } kp_state_t;

  localparam logic [3:0] KEY_OK   = 4'hA;  // key A
  localparam logic [3:0] KEY_B    = 4'hB;
  localparam logic [3:0] KEY_C    = 4'hC;
  localparam logic [3:0] KEY_D    = 4'hD;
  localparam logic [3:0] KEY_CLR  = 4'hE;  // key *
  localparam logic [3:0] KEY_HASH = 4'hF;  // key #

  // Layout: r0 = 1 2 3 A, r1 = 4 5 6 B, r2 = 7 8 9 C, r3 = * 0 # D.
  function automatic logic [3:0] kp_code(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    case ({row, col})
      4'h0: code = 4'd1;
      4'h1: code = 4'd2;
      4'h2: code = 4'd3;
      4'h3: code = KEY_OK;
      4'h4: code = 4'd4;
      4'h5: code = 4'd5;
      4'h6: code = 4'd6;
      4'h7: code = KEY_B;
      4'h8: code = 4'd7;
      4'h9: code = 4'd8;
      4'hA: code = 4'd9;
      4'hB: code = KEY_C;
      4'hC: code = KEY_CLR;
      4'hD: code = 4'd0;
      4'hE: code = KEY_HASH;
      default: code = KEY_D;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/sync2.sv
// sync2: two-flop synchronizer for bringing asynchronous levels into clk.
//   clk   : destination clock
//   rst   : synchronous active-high reset, loads RESET_VAL into both stages
//   d_i   : asynchronous input bits
//   q_o   : synchronized output, two cycles of latency
module sync2 #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 active-low matrix keypad and emits one clean
// single-cycle event per debounced key press.
//   clk         : system clock
//   rst         : synchronous active-high reset
//   row_in      : keypad rows, active-low, asynchronous
//   col_out     : column drive, active-low, one bit low at a time
//   digit       : value 0-9 of the last digit key, holds between events
//   digit_valid : one-cycle strobe, digit key pressed
//   ok_pulse    : one-cycle strobe, key A pressed
//   clr_pulse   : one-cycle strobe, key * pressed
//   key_held    : high from the event cycle until release is confirmed
module keypad_scanner
  import lock_pkg::*;
#(
  parameter int SCAN_DIV       = 4096,
  parameter int DEBOUNCE_SCANS = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [3:0] digit,
  output logic       digit_valid,
  output logic       ok_pulse,
  output logic       clr_pulse,
  output logic       key_held
);

  localparam int            DW         = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int            CW         = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_DONE   = CW'(DEBOUNCE_SCANS);

  logic [3:0]    rows_sync;
  kp_state_t     state_q, state_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [1:0]    col_q, col_d;
  logic [3:0]    col_out_q;
  logic [1:0]    row_q, row_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    digit_q, digit_d;
  logic          dv_q, dv_d;
  logic          ok_q, ok_d;
  logic          clr_q, clr_d;
  logic          held_q, held_d;

  logic          sample;
  logic          single_key;
  logic [1:0]    hit_row;
  logic          all_high;
  logic          press;
  logic [3:0]    press_code;

  // Idle rows read high, so the synchronizer resets to "no key".
  sync2 #(.WIDTH(4), .RESET_VAL(4'hF)) u_row_sync (
    .clk (clk),
    .rst (rst),
    .d_i (row_in),
    .q_o (rows_sync)
  );

  assign sample   = (dwell_q == DWELL_LAST);
  assign all_high = &rows_sync;

  // A sample is a key only when exactly one row is pulled low.
  always_comb begin
    single_key = 1'b1;
    hit_row    = 2'd0;
    case (rows_sync)
      4'b1110: hit_row = 2'd0;
      4'b1101: hit_row = 2'd1;
      4'b1011: hit_row = 2'd2;
      4'b0111: hit_row = 2'd3;
      default: single_key = 1'b0;
    endcase
  end

  // The column is frozen from first detection, so the current column
  // together with the hit row identifies the key being confirmed.
  assign press_code = kp_code(hit_row, col_q);

  always_comb begin
    state_d = state_q;
    dwell_d = sample ? '0 : dwell_q + DW'(1);
    col_d   = col_q;
    row_d   = row_q;
    cnt_d   = cnt_q;
    digit_d = digit_q;
    dv_d    = 1'b0;
    ok_d    = 1'b0;
    clr_d   = 1'b0;
    held_d  = held_q;
    press   = 1'b0;

    case (state_q)
      SCAN: begin
        if (sample) begin
          if (single_key) begin
            row_d = hit_row;
            cnt_d = CW'(1);
            if (CNT_DONE == CW'(1)) press = 1'b1;
            else                    state_d = DEBOUNCE;
          end else begin
            col_d = col_q + 2'd1;
          end
        end
      end
      DEBOUNCE: begin
        if (sample) begin
          if (single_key && (hit_row == row_q)) begin
            cnt_d = cnt_q + CW'(1);
            if (cnt_q + CW'(1) == CNT_DONE) press = 1'b1;
          end else begin
            state_d = SCAN;
            col_d   = col_q + 2'd1;
          end
        end
      end
      PRESSED: begin
        // Count is reused for consecutive all-high samples.
        state_d = RELEASE;
        cnt_d   = '0;
      end
      RELEASE: begin
        if (sample) begin
          if (all_high) begin
            cnt_d = cnt_q + CW'(1);
            if (cnt_q + CW'(1) == CNT_DONE) begin
              held_d  = 1'b0;
              state_d = SCAN;
              col_d   = col_q + 2'd1;
              cnt_d   = '0;
            end
          end else begin
            cnt_d = '0;
          end
        end
      end
      default: state_d = SCAN;
    endcase

    // Event strobes are registered on the edge that enters PRESSED, so they
    // are visible during the PRESSED cycle itself.
    if (press) begin
      state_d = PRESSED;
      held_d  = 1'b1;
      if (press_code <= 4'd9) begin
        digit_d = press_code;
        dv_d    = 1'b1;
      end else if (press_code == KEY_OK) begin
        ok_d = 1'b1;
      end else if (press_code == KEY_CLR) begin
        clr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= SCAN;
      dwell_q   <= '0;
      col_q     <= 2'd0;
      col_out_q <= 4'b1110;
      row_q     <= 2'd0;
      cnt_q     <= '0;
      digit_q   <= 4'd0;
      dv_q      <= 1'b0;
      ok_q      <= 1'b0;
      clr_q     <= 1'b0;
      held_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      dwell_q   <= dwell_d;
      col_q     <= col_d;
      // Registered one-hot-low drive keeps the keypad pins glitch-free.
      col_out_q <= ~(4'b0001 << col_d);
      row_q     <= row_d;
      cnt_q     <= cnt_d;
      digit_q   <= digit_d;
      dv_q      <= dv_d;
      ok_q      <= ok_d;
      clr_q     <= clr_d;
      held_q    <= held_d;
    end
  end

  assign col_out     = col_out_q;
  assign digit       = digit_q;
  assign digit_valid = dv_q;
  assign ok_pulse    = ok_q;
  assign clr_pulse   = clr_q;
  assign key_held    = held_q;

endmodule
